mac_tx_stream: RTL

- Byte-wide Ethernet MAC transmitter, the parametrised successor of the first-generation MAC TX.
- Takes payload from the upper layer over a valid/ready/last stream and builds a complete frame: preamble, SFD, destination MAC, source MAC, EtherType, payload, zero pad, CRC-32 FCS.
- Drives the MII-side byte interface (out_txen/out_txd), then enforces the inter-packet gap.
- Adds padding, FCS generation, underrun abort and an oversize limit.

---
 rtl/mac_pkg.sv | 39 +++
 rtl/crc32_d8.sv | 23 ++
 rtl/mac_tx_stream.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// Shared MAC definitions: TX state encoding, framing bytes and CRC-32 constants.
// Used by mac_tx_stream and the CRC datapath (and later by the receiver).
package mac_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_PREAMBLE = 4'd1,
    ST_SFD      = 4'd2,
    ST_DEST     = 4'd3,
    ST_SRC      = 4'd4,
    ST_TYPE     = 4'd5,
    ST_PAYLOAD  = 4'd6,
    ST_PAD      = 4'd7,
    ST_FCS      = 4'd8,
    ST_IPG      = 4'd9
  } mac_state_e;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_XOROUT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  // Byte idx of a right-aligned nbytes-wide field, most significant byte first.
  function automatic logic [7:0] field_byte(input logic [47:0] field, input int nbytes,
                                            input int idx);
    logic [47:0] sh;
    sh = field >> (8 * (nbytes - 1 - idx));
    return sh[7:0];
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// Combinational CRC-32 (reflected, poly 0x04C11DB7) advance by one byte, LSB first.
// The caller owns the register, its init and final XOR.
module crc32_d8
  import mac_pkg::*;
(
  input  logic [31:0] in_crc,
  input  logic [7:0]  in_data,
  output logic [31:0] out_crc
);

  localparam logic [31:0] POLY_REFL = reflect32(CRC_POLY);

  logic [31:0] c;

  always_comb begin
    c = in_crc ^ {24'h000000, in_data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ POLY_REFL) : (c >> 1);
    end
    out_crc = c;
  end

endmodule

// File: rtl/mac_tx_stream.sv
// Byte-wide Ethernet MAC transmitter: frames an upstream payload stream with
// preamble/SFD/header, zero pad and FCS, then holds the inter-packet gap.
module mac_tx_stream
  import mac_pkg::*;
#(
  parameter int unsigned PREAMBLE_BYTES = 7,
  parameter int unsigned MIN_PAYLOAD    = 46,
  parameter int unsigned MAX_PAYLOAD    = 1500,
  parameter int unsigned IPG_BYTES      = 12,
  parameter logic [47:0] SRC_MAC        = 48'h02_00_00_00_00_01
) (
  input  logic        in_clk,
  input  logic        in_rst_n,
  input  logic [47:0] in_dest_mac,
  input  logic [15:0] in_ether_type,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        out_ready,
  output logic        out_txen,
  output logic [7:0]  out_txd,
  output logic        out_busy,
  output logic        out_underrun,
  output logic        out_oversize,
  output logic [3:0]  out_dbg_state
);

  localparam int unsigned    CNT_W    = $clog2(MAX_PAYLOAD + 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PREAMBLE_BYTES - 1);
  localparam logic [CNT_W-1:0] MIN_CNT  = CNT_W'(MIN_PAYLOAD);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_PAYLOAD);
  localparam logic [CNT_W-1:0] IPG_LAST = CNT_W'(IPG_BYTES - 1);

  if (MIN_PAYLOAD > MAX_PAYLOAD || IPG_BYTES < 1 || PREAMBLE_BYTES < 1) begin : g_bad_params
    $error("mac_tx_stream: invalid parameter combination");
  end

  // Handshake: a payload byte transfers on a cycle where in_valid && out_ready.
  // out_ready is decoded from the state register only, so it never depends on in_valid.
  mac_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [47:0]      dest_q, dest_d;
  logic [15:0]      type_q, type_d;
  logic [31:0]      crc_q, crc_d, crc_next, fcs_word;
  logic             txen_q, txen_d;
  logic [7:0]       txd_q, txd_d;
  logic             und_q, und_d;
  logic             ovr_q, ovr_d;
  logic             crc_en, crc_init;

  assign cnt_inc  = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
  assign fcs_word = crc_q ^ CRC_XOROUT;

  // Each cycle loads the byte that will be on the MII in the following cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dest_d   = dest_q;
    type_d   = type_q;
    txen_d   = 1'b0;
    txd_d    = 8'h00;
    und_d    = 1'b0;
    ovr_d    = 1'b0;
    crc_en   = 1'b0;
    crc_init = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          dest_d   = in_dest_mac;
          type_d   = in_ether_type;
          crc_init = 1'b1;
          txen_d   = 1'b1;
          txd_d    = PREAMBLE_BYTE;
          if (PREAMBLE_BYTES == 1) begin
            state_d = ST_SFD;
            cnt_d   = '0;
          end else begin
            state_d = ST_PREAMBLE;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      ST_PREAMBLE: begin
        txen_d = 1'b1;
        txd_d  = PREAMBLE_BYTE;
        if (cnt_q == PRE_LAST) begin
          state_d = ST_SFD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_SFD: begin
        txen_d  = 1'b1;
        txd_d   = SFD_BYTE;
        state_d = ST_DEST;
        cnt_d   = '0;
      end
      ST_DEST: begin
        txen_d = 1'b1;
        txd_d  = field_byte(dest_q, 6, int'(cnt_q));
        crc_en = 1'b1;
        if (cnt_q == CNT_W'(5)) begin
          state_d = ST_SRC;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_SRC: begin
        txen_d = 1'b1;
        txd_d  = field_byte(SRC_MAC, 6, int'(cnt_q));
        crc_en = 1'b1;
        if (cnt_q == CNT_W'(5)) begin
          state_d = ST_TYPE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_TYPE: begin
        txen_d = 1'b1;
        txd_d  = field_byte({32'h0, type_q}, 2, int'(cnt_q));
        crc_en = 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_PAYLOAD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_PAYLOAD: begin
        if (in_valid) begin
          txen_d = 1'b1;
          txd_d  = in_data;
          crc_en = 1'b1;
          cnt_d  = cnt_inc;
          if (in_last || cnt_inc == MAX_CNT) begin
            ovr_d = ~in_last;
            if (cnt_inc < MIN_CNT) begin
              state_d = ST_PAD;
            end else begin
              state_d = ST_FCS;
              cnt_d   = '0;
            end
          end
        end else begin
          // The cycle of the drop already counts as the first idle byte of the gap.
          und_d    = 1'b1;
          crc_init = 1'b1;
          if (IPG_BYTES == 1) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            state_d = ST_IPG;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      ST_PAD: begin
        txen_d = 1'b1;
        txd_d  = 8'h00;
        crc_en = 1'b1;
        cnt_d  = cnt_inc;
        if (cnt_inc >= MIN_CNT) begin
          state_d = ST_FCS;
          cnt_d   = '0;
        end
      end
      ST_FCS: begin
        txen_d = 1'b1;
        txd_d  = fcs_word[{cnt_q[1:0], 3'b000} +: 8];
        if (cnt_q == CNT_W'(3)) begin
          state_d  = ST_IPG;
          cnt_d    = '0;
          crc_init = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_IPG: begin
        if (cnt_q >= IPG_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  crc32_d8 u_crc (
    .in_crc  (crc_q),
    .in_data (txd_d),
    .out_crc (crc_next)
  );

  always_comb begin
    crc_d = crc_q;
    if (crc_init) begin
      crc_d = CRC_INIT;
    end else if (crc_en) begin
      crc_d = crc_next;
    end
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dest_q  <= '0;
      type_q  <= '0;
      crc_q   <= CRC_INIT;
      txen_q  <= 1'b0;
      txd_q   <= 8'h00;
      und_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dest_q  <= dest_d;
      type_q  <= type_d;
      crc_q   <= crc_d;
      txen_q  <= txen_d;
      txd_q   <= txd_d;
      und_q   <= und_d;
      ovr_q   <= ovr_d;
    end
  end

  assign out_ready     = (state_q == ST_PAYLOAD);
  assign out_busy      = (state_q != ST_IDLE);
  assign out_txen      = txen_q;
  assign out_txd       = txd_q;
  assign out_underrun  = und_q;
  assign out_oversize  = ovr_q;
  assign out_dbg_state = state_q;

endmodule
